// File: rtl/fighter_move_ctrl.sv
// Per-player fighter motion sequencer: samples the keycode once per frame and
// steps the idle/walk/crouch/jump/land/knock-back machine that owns the sprite position.
module fighter_move_ctrl #(
  parameter int         X_START     = 160,
  parameter int         Y_GROUND    = 400,
  parameter int         X_MIN       = 16,
  parameter int         X_MAX       = 623,
  parameter int         WALK_STEP   = 2,
  parameter int         JUMP_V0     = 12,
  parameter int         GRAVITY     = 1,
  parameter int         LAND_FRAMES = 4,
  parameter int         HIT_FRAMES  = 8,
  parameter int         HIT_STEP    = 3,
  parameter logic [7:0] K_LEFT      = 8'h04,
  parameter logic [7:0] K_RIGHT     = 8'h07,
  parameter logic [7:0] K_CROUCH    = 8'h16,
  parameter logic [7:0] K_JUMP      = 8'h1A
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       hit,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic [2:0] State,
  output logic       Facing,
  output logic       Airborne
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WALK   = 3'd1,
    S_CROUCH = 3'd2,
    S_JUMP   = 3'd3,
    S_LAND   = 3'd4,
    S_HIT    = 3'd5
  } state_t;

  localparam logic signed [10:0] XMIN_S  = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S  = 11'(X_MAX);
  localparam logic signed [10:0] WSTEP_S = 11'(WALK_STEP);
  localparam logic signed [10:0] HSTEP_S = 11'(HIT_STEP);
  localparam logic signed [10:0] YGND_S  = 11'(Y_GROUND);
  localparam logic [9:0]         X_RST   = 10'(X_START);
  localparam logic [9:0]         Y_GND   = 10'(Y_GROUND);
  localparam logic signed [5:0]  VY_JUMP = 6'(-JUMP_V0);
  localparam logic signed [5:0]  VY_GRAV = 6'(GRAVITY);
  localparam logic [3:0]         LAND_CNT = 4'(LAND_FRAMES);
  localparam logic [3:0]         HIT_CNT  = 4'(HIT_FRAMES);

  state_t             state_reg;
  logic signed [5:0]  vy_reg;
  logic [1:0]         jump_dir_reg;   // {moves horizontally, moves left}
  logic [3:0]         cnt_reg;
  logic               hit_latch_reg;

  logic signed [10:0] pos_x_s;
  logic signed [10:0] ny_s;
  logic [9:0]         x_left;
  logic [9:0]         x_right;
  logic [9:0]         x_hit;
  logic [9:0]         x_jump;

  // Walls hold the sprite at the limit; signed math keeps a step past 0 from wrapping.
  function automatic logic [9:0] clamp_x(input logic signed [10:0] x);
    if (x < XMIN_S)      return XMIN_S[9:0];
    else if (x > XMAX_S) return XMAX_S[9:0];
    else                 return x[9:0];
  endfunction

  always_comb begin
    pos_x_s = signed'({1'b0, PosX});
    ny_s    = signed'({1'b0, PosY}) + signed'({{5{vy_reg[5]}}, vy_reg});
    x_left  = clamp_x(pos_x_s - WSTEP_S);
    x_right = clamp_x(pos_x_s + WSTEP_S);
    x_hit   = Facing ? clamp_x(pos_x_s + HSTEP_S) : clamp_x(pos_x_s - HSTEP_S);
    x_jump  = PosX;
    if (jump_dir_reg[1])
      x_jump = jump_dir_reg[0] ? x_left : x_right;
  end

  assign State = state_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= S_IDLE;
      PosX          <= X_RST;
      PosY          <= Y_GND;
      Facing        <= 1'b0;
      Airborne      <= 1'b0;
      vy_reg        <= '0;
      jump_dir_reg  <= '0;
      cnt_reg       <= '0;
      hit_latch_reg <= 1'b0;
    end else if (frame_tick) begin
      hit_latch_reg <= 1'b0;
      if (hit_latch_reg || hit) begin
        state_reg <= S_HIT;
        cnt_reg   <= HIT_CNT;
        PosY      <= Y_GND;
        vy_reg    <= '0;
        Airborne  <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE, S_WALK, S_CROUCH: begin
            if (keycode == K_JUMP) begin
              state_reg    <= S_JUMP;
              vy_reg       <= VY_JUMP;
              jump_dir_reg <= (state_reg == S_WALK) ? {1'b1, Facing} : 2'b00;
              Airborne     <= 1'b1;
            end else if (keycode == K_LEFT) begin
              state_reg <= S_WALK;
              Facing    <= 1'b1;
              PosX      <= x_left;
            end else if (keycode == K_RIGHT) begin
              state_reg <= S_WALK;
              Facing    <= 1'b0;
              PosX      <= x_right;
            end else if (keycode == K_CROUCH) begin
              state_reg <= S_CROUCH;
            end else begin
              state_reg <= S_IDLE;
            end
          end
          S_JUMP: begin
            if (ny_s >= YGND_S) begin
              PosY      <= Y_GND;
              vy_reg    <= '0;
              state_reg <= S_LAND;
              cnt_reg   <= LAND_CNT;
              Airborne  <= 1'b0;
            end else begin
              PosY   <= ny_s[9:0];
              vy_reg <= vy_reg + VY_GRAV;
              PosX   <= x_jump;
            end
          end
          S_LAND: begin
            cnt_reg <= cnt_reg - 4'd1;
            if (cnt_reg <= 4'd1) begin
              cnt_reg   <= '0;
              state_reg <= S_IDLE;
            end
          end
          S_HIT: begin
            PosX    <= x_hit;
            cnt_reg <= cnt_reg - 4'd1;
            if (cnt_reg <= 4'd1) begin
              cnt_reg   <= '0;
              state_reg <= S_IDLE;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end else if (hit) begin
      hit_latch_reg <= 1'b1;
    end
  end

endmodule
